regfile_wb_ctrl: RTL and testbench

// - Write-side controller for the 32x32 register file write port (ctrl_writeEnable/ctrl_writeReg/data_writeReg).
// - Merges two result producers: in-order pipeline writeback (pipe_*) and the multicycle mult/div unit (md_*).
// - md_* results are buffered in a small FIFO; one register write is issued per cycle.
// - Keeps a busy scoreboard of registers with an outstanding mult/div result, used by decode for hazard stalls.

---
 rtl/regfile_wb_ctrl.sv | 146 ++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
// Write-side controller for the 32x32 register file write port. It merges the
// in-order pipeline writeback with buffered mult/div results and issues at most
// one register write per cycle. It also keeps a busy scoreboard of registers
// that still have a mult/div result outstanding.
//
// Optional feature macro: WB_BYPASS_EN (adds write-port read forwarding).
//
// Ports:
//   clock, ctrl_reset              rising-edge clock, synchronous active-high reset
//   pipe_we, pipe_reg, pipe_data   pipeline writeback request (held while pipe_ready=0)
//   pipe_ready                     0 = pipeline write not taken this cycle
//   md_issue, md_issue_reg         mult/div op issued; marks its destination busy
//   md_valid, md_reg, md_data      mult/div result, transferred when md_valid & md_ready
//   md_ready                       result FIFO has room
//   busy_vec                       bit i = register i has a pending mult/div write
//   ctrl_writeEnable, ctrl_writeReg, data_writeReg   registered register-file write port
//   ctrl_readRegA/B, data_regA/B, fwd_A/B           (WB_BYPASS_EN) read forwarding
module regfile_wb_ctrl #(
  parameter int MD_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_reg,
  input  logic [31:0] pipe_data,
  output logic        pipe_ready,
  input  logic        md_issue,
  input  logic [4:0]  md_issue_reg,
  input  logic        md_valid,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic [31:0] busy_vec,
`ifdef WB_BYPASS_EN
  input  logic [4:0]  ctrl_readRegA,
  input  logic [4:0]  ctrl_readRegB,
  input  logic [31:0] data_regA,
  input  logic [31:0] data_regB,
  output logic [31:0] fwd_A,
  output logic [31:0] fwd_B,
`endif
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg
);

  localparam int AW = $clog2(MD_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic [AW:0]   DEPTH = (AW+1)'(MD_DEPTH);

  logic [4:0]    fifo_reg  [MD_DEPTH];
  logic [31:0]   fifo_data [MD_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] starve_cnt;

  logic        nonempty;
  logic        full;
  logic        pipe_req;
  logic        force_head;
  logic        head_wins;
  logic        pipe_wins;
  logic        push;
  logic [4:0]  head_reg;
  logic [31:0] head_data;
  logic [31:0] busy_nxt;

  // All decisions use start-of-cycle occupancy: a full FIFO refuses a push
  // even in a cycle where it also pops.
  assign nonempty   = (count != '0);
  assign full       = (count == DEPTH);
  assign head_reg   = fifo_reg[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];
  assign pipe_req   = pipe_we && (pipe_reg != 5'd0);
  assign force_head = nonempty && (starve_cnt >= LIMIT);
  assign head_wins  = force_head || (nonempty && !pipe_req);
  assign pipe_wins  = pipe_req && !force_head;
  assign push       = md_valid && !full;

  // Writes to r0 are acked and dropped, so the pipe only stalls when forced out.
  assign pipe_ready = ctrl_reset || !force_head;
  assign md_ready   = ctrl_reset || !full;

  // Issue and retire of the same register in one cycle: the set wins.
  always_comb begin
    busy_nxt = busy_vec;
    if (head_wins) busy_nxt[head_reg] = 1'b0;
    if (md_issue && (md_issue_reg != 5'd0)) busy_nxt[md_issue_reg] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset && push) begin
      fifo_reg[wr_ptr]  <= md_reg;
      fifo_data[wr_ptr] <= md_data;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      starve_cnt       <= '0;
      busy_vec         <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= 5'd0;
      data_writeReg    <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (head_wins) rd_ptr <= rd_ptr + 1'b1;
      if (push && !head_wins) count <= count + 1'b1;
      else if (!push && head_wins) count <= count - 1'b1;

      if (!nonempty || head_wins) starve_cnt <= '0;
      else if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + 1'b1;

      busy_vec <= busy_nxt;

      // md results for r0 are popped without producing a write.
      if (pipe_wins) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= pipe_reg;
        data_writeReg    <= pipe_data;
      end else if (head_wins && (head_reg != 5'd0)) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= head_reg;
        data_writeReg    <= head_data;
      end else begin
        ctrl_writeEnable <= 1'b0;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Covers the write-port cycle before the register file has committed.
  assign fwd_A = (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA) && (ctrl_readRegA != 5'd0))
                 ? data_writeReg : data_regA;
  assign fwd_B = (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB) && (ctrl_readRegB != 5'd0))
                 ? data_writeReg : data_regB;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;
  localparam int MD_DEPTH     = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        pipe_we;
  logic [4:0]  pipe_reg;
  logic [31:0] pipe_data;
  logic        pipe_ready;
  logic        md_issue;
  logic [4:0]  md_issue_reg;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic [31:0] busy_vec;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
`ifdef WB_BYPASS_EN
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_regA;
  logic [31:0] data_regB;
  logic [31:0] fwd_A;
  logic [31:0] fwd_B;
`endif

  regfile_wb_ctrl #(.MD_DEPTH(MD_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .pipe_we(pipe_we), .pipe_reg(pipe_reg), .pipe_data(pipe_data), .pipe_ready(pipe_ready),
    .md_issue(md_issue), .md_issue_reg(md_issue_reg),
    .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
    .busy_vec(busy_vec),
`ifdef WB_BYPASS_EN
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_regA(data_regA), .data_regB(data_regB), .fwd_A(fwd_A), .fwd_B(fwd_B),
`endif
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result queue, starvation count, busy set, expected write.
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  int          scnt = 0;
  logic [31:0] mbusy = '0;
  logic        exp_we = 1'b0;
  logic [4:0]  exp_reg = '0;
  logic [31:0] exp_data = '0;
  bit          exp_rst = 1'b0;

  task automatic model_step();
    bit   ne, fl, fw, preq, hw;
    ent_t h;
    ent_t e;
    if (ctrl_reset) begin
      q.delete();
      scnt = 0;
      mbusy = '0;
      exp_we = 1'b0;
      exp_reg = '0;
      exp_data = '0;
      exp_rst = 1'b1;
      return;
    end
    exp_rst = 1'b0;
    ne = (q.size() != 0);
    fl = (q.size() >= MD_DEPTH);
    fw = ne && (scnt >= STARVE_LIMIT);
    preq = pipe_we && (pipe_reg != 5'd0);
    hw = fw || (ne && !preq);
    exp_we = 1'b0;
    if (hw) begin
      h = q.pop_front();
      mbusy[h.r] = 1'b0;
      if (h.r != 5'd0) begin
        exp_we = 1'b1;
        exp_reg = h.r;
        exp_data = h.d;
      end
      scnt = 0;
    end else if (preq) begin
      exp_we = 1'b1;
      exp_reg = pipe_reg;
      exp_data = pipe_data;
      if (!ne) scnt = 0;
      else if (scnt < STARVE_LIMIT) scnt = scnt + 1;
    end else begin
      scnt = 0;
    end
    if (md_issue && (md_issue_reg != 5'd0)) mbusy[md_issue_reg] = 1'b1;
    if (md_valid && !fl) begin
      e.r = md_reg;
      e.d = md_data;
      q.push_back(e);
    end
  endtask

  // Inputs change 2 time units after the rising edge; compare and model
  // advance happen on the falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("wr_en", {31'd0, ctrl_writeEnable}, {31'd0, exp_we});
      if (exp_we || exp_rst) begin
        check("wr_reg", {27'd0, ctrl_writeReg}, {27'd0, exp_reg});
        check("wr_data", data_writeReg, exp_data);
      end
      check("busy_vec", busy_vec, mbusy);
      check("pipe_ready", {31'd0, pipe_ready},
            {31'd0, ctrl_reset || !((q.size() != 0) && (scnt >= STARVE_LIMIT))});
      check("md_ready", {31'd0, md_ready}, {31'd0, ctrl_reset || (q.size() < MD_DEPTH)});
`ifdef WB_BYPASS_EN
      check("fwd_A", fwd_A, (exp_we && exp_reg == ctrl_readRegA && ctrl_readRegA != 5'd0) ? exp_data : data_regA);
      check("fwd_B", fwd_B, (exp_we && exp_reg == ctrl_readRegB && ctrl_readRegB != 5'd0) ? exp_data : data_regB);
`endif
    end
    model_step();
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs();
    pipe_we = 1'b0; pipe_reg = '0; pipe_data = '0;
    md_issue = 1'b0; md_issue_reg = '0;
    md_valid = 1'b0; md_reg = '0; md_data = '0;
  endtask

  task automatic md_push(input logic [4:0] r, input logic [31:0] d);
    bit acc;
    bit done;
    done = 1'b0;
    md_valid = 1'b1; md_reg = r; md_data = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      acc = md_ready;
      step();
      if (acc) done = 1'b1;
    end
    md_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL md_push_timeout: got no md_ready expected md_ready=1 within 20 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
`ifdef WB_BYPASS_EN
    ctrl_readRegA = '0; ctrl_readRegB = '0;
    data_regA = 32'h1111_1111; data_regB = 32'h2222_2222;
`endif
    // Reset held two cycles with live requests.
    ctrl_reset = 1'b1;
    pipe_we = 1'b1; pipe_reg = 5'd5; pipe_data = 32'hFFFF_0000;
    md_valid = 1'b1; md_reg = 5'd3; md_data = 32'h3;
    step();
    chk_en = 1'b1;
    @(negedge clock);
    check("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    check("rst_busy", busy_vec, 32'd0);
    check("rst_md_ready", {31'd0, md_ready}, 32'd1);
    check("rst_pipe_ready", {31'd0, pipe_ready}, 32'd1);
    step();
    ctrl_reset = 1'b0;
    idle_inputs();
    step();

    // Pipeline-only write.
    pipe_we = 1'b1; pipe_reg = 5'd5; pipe_data = 32'hDEAD_BEEF;
    step();
    pipe_we = 1'b0;
    @(negedge clock);
    check("pipe_we", {31'd0, ctrl_writeEnable}, 32'd1);
    check("pipe_reg", {27'd0, ctrl_writeReg}, 32'd5);
    check("pipe_data", data_writeReg, 32'hDEAD_BEEF);
    step();

    // Scoreboard for r7.
    md_issue = 1'b1; md_issue_reg = 5'd7;
    step();
    md_issue = 1'b0;
    @(negedge clock);
    check("busy7_set", {31'd0, busy_vec[7]}, 32'd1);
    step();
    md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h1234;
    step();
    md_valid = 1'b0;
    @(negedge clock);
    check("busy7_hold", {31'd0, busy_vec[7]}, 32'd1);
    check("busy7_nowr", {31'd0, ctrl_writeEnable}, 32'd0);
    step();
    @(negedge clock);
    check("r7_we", {31'd0, ctrl_writeEnable}, 32'd1);
    check("r7_reg", {27'd0, ctrl_writeReg}, 32'd7);
    check("r7_data", data_writeReg, 32'h1234);
    check("busy7_clr", {31'd0, busy_vec[7]}, 32'd0);

    // Issue and retire r6 in the same cycle: stays busy.
    md_issue = 1'b1; md_issue_reg = 5'd6;
    step();
    md_issue = 1'b0;
    md_valid = 1'b1; md_reg = 5'd6; md_data = 32'h66;
    step();
    md_valid = 1'b0;
    md_issue = 1'b1; md_issue_reg = 5'd6;
    step();
    md_issue = 1'b0;
    @(negedge clock);
    check("r6_reg", {27'd0, ctrl_writeReg}, 32'd6);
    check("busy6_setwins", {31'd0, busy_vec[6]}, 32'd1);
    step();

    // Starvation: r3 buffered while the pipe streams r9.
    pipe_we = 1'b1; pipe_reg = 5'd9; pipe_data = 32'h99;
    md_valid = 1'b1; md_reg = 5'd3; md_data = 32'h33;
    step();
    md_valid = 1'b0;
    @(negedge clock);
    check("starve_first", {27'd0, ctrl_writeReg}, 32'd9);
    for (int i = 0; i < 4; i++) begin
      check("starve_pipe_ready", {31'd0, pipe_ready}, 32'd1);
      step();
      @(negedge clock);
      check("starve_pipe_wr", {27'd0, ctrl_writeReg}, 32'd9);
    end
    check("starve_forced", {31'd0, pipe_ready}, 32'd0);
    step();
    @(negedge clock);
    check("starve_r3_reg", {27'd0, ctrl_writeReg}, 32'd3);
    check("starve_r3_data", data_writeReg, 32'h33);
    check("starve_resume_ready", {31'd0, pipe_ready}, 32'd1);
    step();
    @(negedge clock);
    check("starve_resume_wr", {27'd0, ctrl_writeReg}, 32'd9);
    pipe_we = 1'b0;
    step();

    // Full FIFO while the pipe is busy.
    pipe_we = 1'b1; pipe_reg = 5'd10; pipe_data = 32'hA0;
    md_push(5'd11, 32'hB11);
    md_push(5'd12, 32'hB12);
    md_valid = 1'b1; md_reg = 5'd13; md_data = 32'hB13;
    @(negedge clock);
    check("full_md_ready", {31'd0, md_ready}, 32'd0);
    md_push(5'd13, 32'hB13);
    pipe_we = 1'b0;
    repeat (4) step();

    // r0 handling.
    pipe_we = 1'b1; pipe_reg = 5'd0; pipe_data = 32'h55;
    @(negedge clock);
    check("r0_pipe_ready", {31'd0, pipe_ready}, 32'd1);
    step();
    pipe_we = 1'b0;
    @(negedge clock);
    check("r0_pipe_nowr", {31'd0, ctrl_writeEnable}, 32'd0);
    md_issue = 1'b1; md_issue_reg = 5'd0;
    md_push(5'd0, 32'h77);
    md_issue = 1'b0;
    @(negedge clock);
    check("r0_md_nowr", {31'd0, ctrl_writeEnable}, 32'd0);
    check("r0_busy0", {31'd0, busy_vec[0]}, 32'd0);
    step();

`ifdef WB_BYPASS_EN
    pipe_we = 1'b1; pipe_reg = 5'd4; pipe_data = 32'hAA;
    ctrl_readRegA = 5'd4; data_regA = 32'h1111_1111;
    step();
    pipe_we = 1'b0;
    @(negedge clock);
    check("fwd_A_hit", fwd_A, 32'hAA);
    step();
    ctrl_readRegA = 5'd0; data_regA = 32'h4444_4444;
    @(negedge clock);
    check("fwd_A_r0", fwd_A, 32'h4444_4444);
    step();
`endif

    // Reset mid-operation drops pending results and busy bits.
    pipe_we = 1'b1; pipe_reg = 5'd10; pipe_data = 32'hA1;
    md_push(5'd12, 32'hC12);
    ctrl_reset = 1'b1;
    md_issue = 1'b1; md_issue_reg = 5'd5;
    step();
    ctrl_reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    check("mid_rst_busy", busy_vec, 32'd0);
    check("mid_rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    repeat (3) step();
    @(negedge clock);
    check("mid_rst_dropped", {31'd0, ctrl_writeEnable}, 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
